// File: rtl/csr_file_irq.sv
// csr_file_irq -- machine-mode CSR file with interrupt support.
//
// Holds the M-mode trap/interrupt CSRs, the 64-bit mcycle/minstret counters
// (gated by mcountinhibit), a two-flop synchroniser for each asynchronous
// interrupt line, the prioritised interrupt request and the trap handler
// address. It sits beside decode/execute and serves CSR instructions, trap
// entry and MRET.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   csr_addr/csr_wdata/csr_op     CSR access (funct3 encodings RW/RS/RC and imm forms)
//   csr_we                        commit the CSR write this cycle
//   csr_rdata, illegal_csr        combinational read data / illegal access flag
//   trap_entry/trap_is_irq/...    trap commit with cause, pc and tval
//   trap_vector                   handler address (combinational)
//   mret, mepc_out                MRET commit, current mepc
//   instr_ret                     one instruction retired this cycle
//   irq_ext/irq_timer/irq_sw      asynchronous interrupt levels
//   irq_req/irq_code/mstatus_mie  interrupt request, winning code, global enable
module csr_file_irq #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] HART_ID   = '0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter bit              VECTORED  = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [2:0]      csr_op,
  input  logic            csr_we,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal_csr,
  input  logic            trap_entry,
  input  logic            trap_is_irq,
  input  logic [4:0]      trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  output logic [XLEN-1:0] trap_vector,
  input  logic            mret,
  output logic [XLEN-1:0] mepc_out,
  input  logic            instr_ret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  output logic            irq_req,
  output logic [4:0]      irq_code,
  output logic            mstatus_mie
);

  localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] ADDR_MISA          = 12'h301;
  localparam logic [11:0] ADDR_MIE           = 12'h304;
  localparam logic [11:0] ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] ADDR_MEPC          = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] ADDR_MTVAL         = 12'h343;
  localparam logic [11:0] ADDR_MIP           = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID       = 12'hF14;
  localparam logic [1:0]  MISA_MXL           = (XLEN == 32) ? 2'b01 : 2'b10;

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            meie_q, meie_d, mtie_q, mtie_d, msie_q, msie_d;
  logic [XLEN-1:2] mtvec_base_q, mtvec_base_d;
  logic            mtvec_mode_q, mtvec_mode_d;
  logic            cy_inhibit_q, cy_inhibit_d, ir_inhibit_q, ir_inhibit_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
  // Bit order {ext, timer, sw}; meta is the first synchroniser stage.
  logic [2:0]      irq_meta_q, irq_meta_d, irq_sync_q, irq_sync_d;

  logic            csr_known, csr_ro, op_valid, wr_en;
  logic [XLEN-1:0] wval;
  logic [63:0]     wval64;
  logic            pend_ext, pend_tmr, pend_sw;

  // Read mux; also classifies the address as known / read-only.
  always_comb begin
    csr_known = 1'b1;
    csr_ro    = 1'b0;
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[3]     = mstatus_mie_q;
        csr_rdata[7]     = mstatus_mpie_q;
        csr_rdata[12:11] = 2'b11;
      end
      ADDR_MISA: begin
        csr_ro                    = 1'b1;
        csr_rdata[XLEN-1:XLEN-2]  = MISA_MXL;
        csr_rdata[8]              = 1'b1;
      end
      ADDR_MIE: begin
        csr_rdata[11] = meie_q;
        csr_rdata[7]  = mtie_q;
        csr_rdata[3]  = msie_q;
      end
      ADDR_MTVEC:    csr_rdata = {mtvec_base_q, 1'b0, mtvec_mode_q};
      ADDR_MCOUNTINHIBIT: begin
        csr_rdata[0] = cy_inhibit_q;
        csr_rdata[2] = ir_inhibit_q;
      end
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = mepc_q;
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MTVAL:    csr_rdata = mtval_q;
      ADDR_MIP: begin
        csr_rdata[11] = irq_sync_q[2];
        csr_rdata[7]  = irq_sync_q[1];
        csr_rdata[3]  = irq_sync_q[0];
      end
      ADDR_MCYCLE:   csr_rdata = mcycle_q[XLEN-1:0];
      ADDR_MINSTRET: csr_rdata = minstret_q[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (XLEN == 32) csr_rdata = XLEN'(mcycle_q[63:32]);
        else            csr_known = 1'b0;
      end
      ADDR_MINSTRETH: begin
        if (XLEN == 32) csr_rdata = XLEN'(minstret_q[63:32]);
        else            csr_known = 1'b0;
      end
      ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: csr_ro = 1'b1;
      ADDR_MHARTID: begin
        csr_ro    = 1'b1;
        csr_rdata = HART_ID;
      end
      default: csr_known = 1'b0;
    endcase
  end

  assign illegal_csr = ~csr_known | (csr_we & csr_ro);

  // Read-modify-write value; funct3 x00 encodings carry no write.
  always_comb begin
    op_valid = 1'b1;
    wval     = '0;
    case (csr_op)
      3'b001, 3'b101: wval = csr_wdata;
      3'b010, 3'b110: wval = csr_rdata | csr_wdata;
      3'b011, 3'b111: wval = csr_rdata & ~csr_wdata;
      default:        op_valid = 1'b0;
    endcase
  end

  // Trap entry and MRET both pre-empt a CSR write in the same cycle.
  assign wr_en  = csr_we & ~illegal_csr & op_valid & ~trap_entry & ~mret;
  assign wval64 = 64'(wval);

  // Next-state: counters tick first, then trap > mret > CSR write.
  // A counter write overrides only the addressed half; the other half keeps
  // its pre-write value, so no carry crosses into it that cycle.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    meie_d         = meie_q;
    mtie_d         = mtie_q;
    msie_d         = msie_q;
    mtvec_base_d   = mtvec_base_q;
    mtvec_mode_d   = mtvec_mode_q;
    cy_inhibit_d   = cy_inhibit_q;
    ir_inhibit_d   = ir_inhibit_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcycle_d       = cy_inhibit_q ? mcycle_q : mcycle_q + 64'd1;
    minstret_d     = (instr_ret & ~ir_inhibit_q) ? minstret_q + 64'd1 : minstret_q;
    irq_meta_d     = {irq_ext, irq_timer, irq_sw};
    irq_sync_d     = irq_meta_q;

    if (trap_entry) begin
      mepc_d              = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d            = '0;
      mcause_d[XLEN-1]    = trap_is_irq;
      mcause_d[4:0]       = trap_cause;
      mtval_d             = trap_is_irq ? '0 : trap_val;
      mstatus_mpie_d      = mstatus_mie_q;
      mstatus_mie_d       = 1'b0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        ADDR_MIE: begin
          meie_d = wval[11];
          mtie_d = wval[7];
          msie_d = wval[3];
        end
        ADDR_MTVEC: begin
          mtvec_base_d = wval[XLEN-1:2];
          mtvec_mode_d = VECTORED & wval[0];
        end
        ADDR_MCOUNTINHIBIT: begin
          cy_inhibit_d = wval[0];
          ir_inhibit_d = wval[2];
        end
        ADDR_MSCRATCH:  mscratch_d = wval;
        ADDR_MEPC:      mepc_d     = {wval[XLEN-1:2], 2'b00};
        ADDR_MCAUSE:    mcause_d   = wval;
        ADDR_MTVAL:     mtval_d    = wval;
        ADDR_MCYCLE:    mcycle_d   = (XLEN == 32) ? {mcycle_q[63:32], wval64[31:0]} : wval64;
        ADDR_MINSTRET:  minstret_d = (XLEN == 32) ? {minstret_q[63:32], wval64[31:0]} : wval64;
        ADDR_MCYCLEH:   mcycle_d   = {wval64[31:0], mcycle_q[31:0]};
        ADDR_MINSTRETH: minstret_d = {wval64[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      meie_q         <= 1'b0;
      mtie_q         <= 1'b0;
      msie_q         <= 1'b0;
      mtvec_base_q   <= MTVEC_RST[XLEN-1:2];
      mtvec_mode_q   <= 1'b0;
      cy_inhibit_q   <= 1'b0;
      ir_inhibit_q   <= 1'b0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      irq_meta_q     <= '0;
      irq_sync_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      meie_q         <= meie_d;
      mtie_q         <= mtie_d;
      msie_q         <= msie_d;
      mtvec_base_q   <= mtvec_base_d;
      mtvec_mode_q   <= mtvec_mode_d;
      cy_inhibit_q   <= cy_inhibit_d;
      ir_inhibit_q   <= ir_inhibit_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      irq_meta_q     <= irq_meta_d;
      irq_sync_q     <= irq_sync_d;
    end
  end

  // Interrupt arbitration: MEI beats MSI beats MTI.
  assign pend_ext    = meie_q & irq_sync_q[2];
  assign pend_tmr    = mtie_q & irq_sync_q[1];
  assign pend_sw     = msie_q & irq_sync_q[0];
  assign irq_req     = mstatus_mie_q & (pend_ext | pend_tmr | pend_sw);
  assign irq_code    = !irq_req ? 5'd0 : pend_ext ? 5'd11 : pend_sw ? 5'd3 : 5'd7;
  assign mstatus_mie = mstatus_mie_q;
  assign mepc_out    = mepc_q;

  // Vectored mode only redirects interrupts; exceptions use the base.
  assign trap_vector = (mtvec_mode_q && trap_is_irq)
                     ? {mtvec_base_q, 2'b00} + XLEN'({trap_cause, 2'b00})
                     : {mtvec_base_q, 2'b00};

endmodule

// File: tb/tb_csr_file_irq.sv
// Testbench for csr_file_irq: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// behavioural model of the CSR file kept in this bench.
module tb_csr_file_irq;

  localparam logic [31:0] TB_HART  = 32'h0000_0005;
  localparam logic [31:0] TB_MTVEC = 32'h0000_0203;
  localparam logic [2:0]  OP_RW = 3'b001, OP_RS = 3'b010, OP_RC = 3'b011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [2:0]  csr_op;
  logic        csr_we;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        trap_entry, trap_is_irq;
  logic [4:0]  trap_cause;
  logic [31:0] trap_pc, trap_val, trap_vector, mepc_out;
  logic        mret, instr_ret, irq_ext, irq_timer, irq_sw;
  logic        irq_req, mstatus_mie;
  logic [4:0]  irq_code;

  logic [11:0] addr64;
  logic [63:0] rdata64, tvec64, mepc64;
  logic        illegal64, req64, mie64;
  logic [4:0]  code64;

  int passCount  = 0;
  int checkCount = 0;

  // Model state
  logic        mValid = 1'b0;
  logic        mGie, mMpie;
  logic [31:0] mMieEn, mMtvec, mInh, mScratch, mMepc, mMcause, mMtval;
  logic [63:0] mCyc, mIns;
  logic [2:0]  mH1, mH2;

  csr_file_irq #(.XLEN(32), .HART_ID(TB_HART), .MTVEC_RST(TB_MTVEC), .VECTORED(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_op(csr_op), .csr_we(csr_we), .csr_rdata(csr_rdata), .illegal_csr(illegal_csr),
    .trap_entry(trap_entry), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .trap_vector(trap_vector), .mret(mret),
    .mepc_out(mepc_out), .instr_ret(instr_ret), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_sw(irq_sw), .irq_req(irq_req), .irq_code(irq_code), .mstatus_mie(mstatus_mie)
  );

  csr_file_irq #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .csr_addr(addr64), .csr_wdata(64'd0),
    .csr_op(3'b000), .csr_we(1'b0), .csr_rdata(rdata64), .illegal_csr(illegal64),
    .trap_entry(1'b0), .trap_is_irq(1'b0), .trap_cause(5'd0),
    .trap_pc(64'd0), .trap_val(64'd0), .trap_vector(tvec64), .mret(1'b0),
    .mepc_out(mepc64), .instr_ret(1'b0), .irq_ext(1'b0), .irq_timer(1'b0),
    .irq_sw(1'b0), .irq_req(req64), .irq_code(code64), .mstatus_mie(mie64)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model lookup: {legal, read-only, value}
  function automatic logic [33:0] modelRead(input logic [11:0] a);
    logic [31:0] v;
    logic ok, ro;
    v = 32'd0; ok = 1'b1; ro = 1'b0;
    case (a)
      12'h300: v = 32'h1800 | (32'(mMpie) << 7) | (32'(mGie) << 3);
      12'h301: begin v = 32'h4000_0100; ro = 1'b1; end
      12'h304: v = mMieEn;
      12'h305: v = mMtvec;
      12'h320: v = mInh;
      12'h340: v = mScratch;
      12'h341: v = mMepc;
      12'h342: v = mMcause;
      12'h343: v = mMtval;
      12'h344: v = (32'(mH2[2]) << 11) | (32'(mH2[1]) << 7) | (32'(mH2[0]) << 3);
      12'hB00: v = mCyc[31:0];
      12'hB02: v = mIns[31:0];
      12'hB80: v = mCyc[63:32];
      12'hB82: v = mIns[63:32];
      12'hF11, 12'hF12, 12'hF13: ro = 1'b1;
      12'hF14: begin v = TB_HART; ro = 1'b1; end
      default: ok = 1'b0;
    endcase
    return {ok, ro, v};
  endfunction

  // Model state update on every rising edge
  always @(posedge clk) begin : modelUpdate
    logic [33:0] r;
    logic [31:0] nv;
    logic [63:0] cycN, insN;
    if (!reset_n) begin
      mGie = 0; mMpie = 0; mMieEn = 0; mMtvec = TB_MTVEC & ~32'd3; mInh = 0;
      mScratch = 0; mMepc = 0; mMcause = 0; mMtval = 0; mCyc = 0; mIns = 0;
      mH1 = 0; mH2 = 0; mValid = 1'b1;
    end else begin
      cycN = mInh[0] ? mCyc : mCyc + 64'd1;
      insN = (instr_ret && !mInh[2]) ? mIns + 64'd1 : mIns;
      r = modelRead(csr_addr);
      if (trap_entry) begin
        mMepc   = trap_pc & ~32'd3;
        mMcause = (trap_is_irq ? 32'h8000_0000 : 32'd0) | 32'(trap_cause);
        mMtval  = trap_is_irq ? 32'd0 : trap_val;
        mMpie   = mGie;
        mGie    = 1'b0;
      end else if (mret) begin
        mGie  = mMpie;
        mMpie = 1'b1;
      end else if (csr_we && r[33] && !r[32] && csr_op[1:0] != 2'b00) begin
        case (csr_op[1:0])
          2'b01:   nv = csr_wdata;
          2'b10:   nv = r[31:0] | csr_wdata;
          default: nv = r[31:0] & ~csr_wdata;
        endcase
        case (csr_addr)
          12'h300: begin mGie = nv[3]; mMpie = nv[7]; end
          12'h304: mMieEn = nv & 32'h888;
          12'h305: mMtvec = nv & ~32'd2;
          12'h320: mInh = nv & 32'd5;
          12'h340: mScratch = nv;
          12'h341: mMepc = nv & ~32'd3;
          12'h342: mMcause = nv;
          12'h343: mMtval = nv;
          12'hB00: cycN = {mCyc[63:32], nv};
          12'hB02: insN = {mIns[63:32], nv};
          12'hB80: cycN = {nv, mCyc[31:0]};
          12'hB82: insN = {nv, mIns[31:0]};
          default: ;
        endcase
      end
      mCyc = cycN;
      mIns = insN;
      mH2 = mH1;
      mH1 = {irq_ext, irq_timer, irq_sw};
    end
  end

  // Compare process: every output against the model, away from the edge
  always @(negedge clk) begin : compareProc
    logic [33:0] r;
    logic [31:0] base, tv;
    logic [11:0] pend;
    logic        req;
    logic [4:0]  code;
    if (mValid) begin
      r    = modelRead(csr_addr);
      base = mMtvec & ~32'd3;
      tv   = ((mMtvec & 32'd3) == 32'd1 && trap_is_irq) ? base + 32'd4 * 32'(trap_cause) : base;
      pend = mMieEn[11:0] & {mH2[2], 3'b0, mH2[1], 3'b0, mH2[0], 3'b0};
      req  = mGie && (pend[11] || pend[7] || pend[3]);
      code = !req ? 5'd0 : pend[11] ? 5'd11 : pend[3] ? 5'd3 : 5'd7;
      checkOutput("cmp_rdata", 64'(csr_rdata), 64'(r[31:0]));
      checkOutput("cmp_illegal", 64'(illegal_csr), 64'(!r[33] || (csr_we && r[32])));
      checkOutput("cmp_trap_vector", 64'(trap_vector), 64'(tv));
      checkOutput("cmp_mepc_out", 64'(mepc_out), 64'(mMepc));
      checkOutput("cmp_irq_req", 64'(irq_req), 64'(req));
      checkOutput("cmp_irq_code", 64'(irq_code), 64'(code));
      checkOutput("cmp_mstatus_mie", 64'(mstatus_mie), 64'(mGie));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [11:0] a, input logic [2:0] op,
                               input logic [31:0] d, input logic te, input logic ti,
                               input logic [4:0] tc, input logic [31:0] tp,
                               input logic [31:0] tvl, input logic mr);
    csr_we = we; csr_addr = a; csr_op = op; csr_wdata = d;
    trap_entry = te; trap_is_irq = ti; trap_cause = tc; trap_pc = tp; trap_val = tvl;
    mret = mr;
  endtask

  task automatic csrWrite(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
    applyStimulus(1'b1, a, op, d, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    csr_we = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    checkOutput(name, 64'(csr_rdata), 64'(exp));
  endtask

  task automatic waitIrq(input string name);
    for (int i = 0; i < 4 && !irq_req; i++) tick();
    checkOutput(name, 64'(irq_req), 64'd1);
  endtask

  localparam logic [11:0] ADDRS [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320,
    12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
    12'hF11, 12'hF14, 12'h7C0, 12'h000, 12'h300, 12'h304};

  initial begin
    reset_n = 1'b0; instr_ret = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0; addr64 = 12'hB80;
    applyStimulus(1'b0, 12'h300, 3'b000, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) tick();

    // T1: reset values
    readCheck("t1_mstatus", 12'h300, 32'h1800);
    readCheck("t1_mtvec", 12'h305, 32'h200);
    readCheck("t1_misa", 12'h301, 32'h4000_0100);
    readCheck("t1_mhartid", 12'hF14, 32'h5);
    readCheck("t1_mcycle", 12'hB00, 32'h0);
    checkOutput("t1_irq_req", 64'(irq_req), 64'd0);
    checkOutput("t1_irq_code", 64'(irq_code), 64'd0);
    reset_n = 1'b1;
    tick();

    // T2: interrupt request and priority
    csrWrite(12'h304, OP_RW, 32'h800);
    csrWrite(12'h300, OP_RS, 32'h8);
    irq_ext = 1'b1;
    waitIrq("t2_req_ext");
    checkOutput("t2_code_ext", 64'(irq_code), 64'd11);
    irq_sw = 1'b1;
    csrWrite(12'h304, OP_RW, 32'h808);
    readCheck("t2_mie", 12'h304, 32'h808);
    repeat (3) tick();
    checkOutput("t2_code_both", 64'(irq_code), 64'd11);
    irq_ext = 1'b0;
    repeat (3) tick();
    checkOutput("t2_req_sw", 64'(irq_req), 64'd1);
    checkOutput("t2_code_sw", 64'(irq_code), 64'd3);
    irq_sw = 1'b0;
    repeat (3) tick();

    // T3: vectored trap
    csrWrite(12'h305, OP_RW, 32'h1001);
    readCheck("t3_mtvec", 12'h305, 32'h1001);
    applyStimulus(1'b0, 12'h342, 3'b000, 32'd0, 1'b0, 1'b0, 5'd7, 32'h2002, 32'hDEAD, 1'b0);
    #1 checkOutput("t3_vector_exc", 64'(trap_vector), 64'h1000);
    applyStimulus(1'b0, 12'h342, 3'b000, 32'd0, 1'b1, 1'b1, 5'd7, 32'h2002, 32'hDEAD, 1'b0);
    #1 checkOutput("t3_vector_irq", 64'(trap_vector), 64'h101C);
    tick();
    trap_entry = 1'b0;
    readCheck("t3_mcause", 12'h342, 32'h8000_0007);
    readCheck("t3_mtval", 12'h343, 32'h0);
    readCheck("t3_mstatus", 12'h300, 32'h1880);
    checkOutput("t3_mepc_out", 64'(mepc_out), 64'h2000);
    applyStimulus(1'b0, 12'h300, 3'b000, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    tick();
    mret = 1'b0;
    readCheck("t3_after_mret", 12'h300, 32'h1888);

    // T4: 64-bit counter wrap across halves, then inhibit
    csrWrite(12'hB80, OP_RW, 32'h0);
    csrWrite(12'hB00, OP_RW, 32'hFFFF_FFFF);
    readCheck("t4_lo_pre", 12'hB00, 32'hFFFF_FFFF);
    readCheck("t4_hi_pre", 12'hB80, 32'h0);
    csrWrite(12'h320, OP_RW, 32'h1);
    readCheck("t4_hi_wrap", 12'hB80, 32'h1);
    readCheck("t4_lo_wrap", 12'hB00, 32'h0);
    repeat (3) tick();
    readCheck("t4_lo_frozen", 12'hB00, 32'h0);
    readCheck("t4_inhibit", 12'h320, 32'h1);
    csrWrite(12'h320, OP_RW, 32'hFFFF_FFFF);
    readCheck("t4_inhibit_mask", 12'h320, 32'h5);
    csrWrite(12'h320, OP_RW, 32'h0);

    // T5: trap beats mret beats CSR write
    csrWrite(12'h340, OP_RW, 32'h55);
    csrWrite(12'h300, OP_RW, 32'h8);
    applyStimulus(1'b1, 12'h340, OP_RW, 32'hAA, 1'b1, 1'b0, 5'd2, 32'h400, 32'h1234, 1'b1);
    tick();
    applyStimulus(1'b0, 12'h340, 3'b000, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    readCheck("t5_mscratch", 12'h340, 32'h55);
    readCheck("t5_mcause", 12'h342, 32'h2);
    readCheck("t5_mtval", 12'h343, 32'h1234);
    readCheck("t5_mstatus", 12'h300, 32'h1880);
    checkOutput("t5_mepc_out", 64'(mepc_out), 64'h400);

    // T6: illegal accesses
    applyStimulus(1'b1, 12'h301, OP_RW, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    #1 checkOutput("t6_misa_we_illegal", 64'(illegal_csr), 64'd1);
    tick();
    csr_we = 1'b0;
    readCheck("t6_misa", 12'h301, 32'h4000_0100);
    #1 checkOutput("t6_misa_read_legal", 64'(illegal_csr), 64'd0);
    addr64 = 12'hB80;
    #1 checkOutput("t6_x64_b80_illegal", 64'(illegal64), 64'd1);
    checkOutput("t6_x64_b80_rdata", rdata64, 64'd0);
    addr64 = 12'h301;
    #1 checkOutput("t6_x64_misa", rdata64, 64'h8000_0000_0000_0100);
    addr64 = 12'hB00;
    #1 checkOutput("t6_x64_mcycle_legal", 64'(illegal64), 64'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, ADDRS[$urandom_range(0, 19)],
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 31)), $urandom, $urandom,
                    $urandom_range(0, 15) == 0);
      instr_ret = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) irq_ext   = ~irq_ext;
      if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(0, 7) == 0) irq_sw    = ~irq_sw;
      reset_n = $urandom_range(0, 199) != 0;
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
